// File: rtl/irq_cond.sv
// Per-line IRQ conditioner: synchroniser chain, stable-count glitch filter with
// per-line bypass, registered level output plus one-cycle rise/fall pulses.
module irq_cond #(
  parameter int unsigned N_IRQ       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] filt_en_i,
  output logic [N_IRQ-1:0] irq_o,
  output logic [N_IRQ-1:0] rise_o,
  output logic [N_IRQ-1:0] fall_o
);

  localparam int unsigned   CW      = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] s;
  logic [CW-1:0]    cnt_q  [N_IRQ];
  logic [CW-1:0]    cnt_d  [N_IRQ];
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] rise_q, fall_q;

  // Plain flop chain; nothing may sit between the stages.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Bypass and "input agrees with output" share one path: follow s, clear count.
  always_comb begin
    irq_d = irq_q;
    for (int unsigned n = 0; n < N_IRQ; n++) begin
      cnt_d[n] = '0;
      if (filt_en_i[n] && (s[n] != irq_q[n])) begin
        if (cnt_q[n] == CNT_MAX) irq_d[n] = s[n];
        else                     cnt_d[n] = cnt_q[n] + CW'(1);
      end else begin
        irq_d[n] = s[n];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int unsigned n = 0; n < N_IRQ; n++) cnt_q[n] <= '0;
    end else begin
      irq_q  <= irq_d;
      rise_q <= irq_d & ~irq_q;
      fall_q <= ~irq_d & irq_q;
      for (int unsigned n = 0; n < N_IRQ; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign irq_o  = irq_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: tb/tb_irq_cond.sv
// Scoreboard bench for irq_cond: stimulus queues cycle-tagged expectations,
// a negedge monitor compares the outputs against whatever is due that cycle.
module tb_irq_cond;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_i, filt_en;
  logic [31:0] irq_o, rise_o, fall_o;

  irq_cond #(
    .N_IRQ      (32),
    .SYNC_STAGES(2),
    .FILT_CYCLES(4)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .irq_i    (irq_i),
    .filt_en_i(filt_en),
    .irq_o    (irq_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] mask;
    logic [31:0] irq;
    logic [31:0] rise;
    logic [31:0] fall;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;
  bit    done   = 1'b0;

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] B0 = 32'h1 << 0;
  localparam logic [31:0] B1 = 32'h1 << 1;
  localparam logic [31:0] B3 = 32'h1 << 3;
  localparam logic [31:0] B5 = 32'h1 << 5;
  localparam logic [31:0] B7 = 32'h1 << 7;
  localparam logic [31:0] B9 = 32'h1 << 9;
  localparam logic [31:0] B31 = 32'h1 << 31;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  task automatic expect_at(input int unsigned c, input logic [31:0] m, input logic [31:0] i,
                           input logic [31:0] r, input logic [31:0] f, input string nm);
    exp_t e;
    e.cyc = c; e.mask = m; e.irq = i; e.rise = r; e.fall = f;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (done || sb[i].cyc == cyc) begin
        checks++;
        if (done) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                   sb_name[i], sb[i].cyc, cyc);
        end else if ((((irq_o ^ sb[i].irq) | (rise_o ^ sb[i].rise) |
                       (fall_o ^ sb[i].fall)) & sb[i].mask) != 0) begin
          errors++;
          $display("FAIL %s cyc=%0d: got irq=%h rise=%h fall=%h, want irq=%h rise=%h fall=%h (mask %h)",
                   sb_name[i], cyc, irq_o, rise_o, fall_o, sb[i].irq, sb[i].rise, sb[i].fall,
                   sb[i].mask);
        end
        sb.delete(i);
        sb_name.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want end");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, j;
    rst_n   = 1'b0;
    irq_i   = ALL;
    filt_en = ALL;

    // 1. Reset held with all lines high, then release.
    for (int d = 1; d <= 3; d++) expect_at(d, ALL, Z, Z, Z, "reset_hold");
    tick(3);
    k = cyc;
    rst_n = 1'b1;
    expect_at(k + 5, ALL, Z, Z, Z, "reset_rel_pre");
    expect_at(k + 6, ALL, ALL, ALL, Z, "reset_rel_rise");
    expect_at(k + 7, ALL, ALL, Z, Z, "reset_rel_post");
    tick(8);
    k = cyc;
    irq_i = Z;
    expect_at(k + 5, ALL, ALL, Z, Z, "all_fall_pre");
    expect_at(k + 6, ALL, Z, Z, ALL, "all_fall");
    expect_at(k + 7, ALL, Z, Z, Z, "all_fall_post");
    tick(8);

    // 2. Glitch rejection on line 3: 3-cycle pulse rejected, 4-cycle accepted.
    k = cyc;
    for (int d = 3; d <= 9; d++) expect_at(k + d, ALL, Z, Z, Z, "glitch3_short");
    irq_i[3] = 1'b1;
    tick(3);
    irq_i[3] = 1'b0;
    tick(8);
    k = cyc;
    expect_at(k + 5,  ALL, Z,  Z,  Z,  "glitch3_pre");
    expect_at(k + 6,  ALL, B3, B3, Z,  "glitch3_rise");
    expect_at(k + 7,  ALL, B3, Z,  Z,  "glitch3_hold");
    expect_at(k + 9,  ALL, B3, Z,  Z,  "glitch3_prefall");
    expect_at(k + 10, ALL, Z,  Z,  B3, "glitch3_fall");
    expect_at(k + 11, ALL, Z,  Z,  Z,  "glitch3_post");
    irq_i[3] = 1'b1;
    tick(4);
    irq_i[3] = 1'b0;
    tick(10);

    // 3. Bypass on line 0: 1-cycle pulse passes through.
    k = cyc;
    expect_at(k + 2, ALL, Z,  Z,  Z,  "bypass0_pre");
    expect_at(k + 3, ALL, B0, B0, Z,  "bypass0_rise");
    expect_at(k + 4, ALL, Z,  Z,  B0, "bypass0_fall");
    expect_at(k + 5, ALL, Z,  Z,  Z,  "bypass0_post");
    filt_en[0] = 1'b0;
    irq_i[0]   = 1'b1;
    tick(1);
    irq_i[0]   = 1'b0;
    tick(6);
    filt_en[0] = 1'b1;

    // 4. Interrupted count on line 5: 3 high, 1 low, 4 high.
    k = cyc;
    for (int d = 3; d <= 9; d++) expect_at(k + d, ALL, Z, Z, Z, "restart5_quiet");
    expect_at(k + 10, ALL, B5, B5, Z,  "restart5_rise");
    expect_at(k + 11, ALL, B5, Z,  Z,  "restart5_hold");
    expect_at(k + 13, ALL, B5, Z,  Z,  "restart5_prefall");
    expect_at(k + 14, ALL, Z,  Z,  B5, "restart5_fall");
    expect_at(k + 15, ALL, Z,  Z,  Z,  "restart5_post");
    irq_i[5] = 1'b1;
    tick(3);
    irq_i[5] = 1'b0;
    tick(1);
    irq_i[5] = 1'b1;
    tick(4);
    irq_i[5] = 1'b0;
    tick(10);

    // 5. Independence: line 1 bypassed, line 31 filtered, toggled together.
    k = cyc;
    expect_at(k + 2, ALL, Z,        Z,   Z, "indep_pre");
    expect_at(k + 3, ALL, B1,       B1,  Z, "indep_rise1");
    expect_at(k + 4, ALL, B1,       Z,   Z, "indep_hold1");
    expect_at(k + 5, ALL, B1,       Z,   Z, "indep_pre31");
    expect_at(k + 6, ALL, B1 | B31, B31, Z, "indep_rise31");
    expect_at(k + 7, ALL, B1 | B31, Z,   Z, "indep_hold31");
    filt_en[1] = 1'b0;
    irq_i[1]   = 1'b1;
    irq_i[31]  = 1'b1;
    tick(8);
    k = cyc;
    expect_at(k + 3, ALL, B31, Z, B1,  "indep_fall1");
    expect_at(k + 4, ALL, B31, Z, Z,   "indep_after1");
    expect_at(k + 5, ALL, B31, Z, Z,   "indep_prefall31");
    expect_at(k + 6, ALL, Z,   Z, B31, "indep_fall31");
    expect_at(k + 7, ALL, Z,   Z, Z,   "indep_post");
    irq_i[1]  = 1'b0;
    irq_i[31] = 1'b0;
    tick(8);
    filt_en[1] = 1'b1;

    // Disabling the filter mid-count on line 9 lets the output follow at once.
    k = cyc;
    expect_at(k + 3, ALL, Z, Z, Z, "midbyp9_pre");
    irq_i[9] = 1'b1;
    tick(3);
    filt_en[9] = 1'b0;
    expect_at(k + 4, ALL, B9, B9, Z, "midbyp9_rise");
    expect_at(k + 5, ALL, B9, Z,  Z, "midbyp9_hold");
    tick(3);
    k = cyc;
    filt_en[9] = 1'b1;
    irq_i[9]   = 1'b0;
    expect_at(k + 5, ALL, B9, Z, Z,  "midbyp9_prefall");
    expect_at(k + 6, ALL, Z,  Z, B9, "midbyp9_fall");
    tick(8);

    // 6. Async reset while line 7 is counting down toward a fall.
    k = cyc;
    expect_at(k + 6, ALL, B7, B7, Z, "areset7_rise");
    irq_i[7] = 1'b1;
    tick(8);
    j = cyc;
    irq_i[7] = 1'b0;
    tick(4);
    expect_at(j + 4, ALL, Z, Z, Z, "areset7_cleared");
    for (int d = 5; d <= 10; d++) expect_at(j + d, ALL, Z, Z, Z, "areset7_quiet");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick(10);

    @(posedge clk);
    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
